booth_dot_scheduler: RTL and testbench

BOOTH_DOT_SCHEDULER -- requirements
Module: booth_dot_scheduler

---
 rtl/booth_dot_scheduler.sv | 141 ++++++++++++++
 tb/tb_booth_dot_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_dot_scheduler.sv
// Sequences operand pairs through a shared external multiplier and
// accumulates a signed dot product with a sticky overflow flag.
module booth_dot_scheduler #(
    parameter int N     = 4,
    parameter int LEN_W = 4,
    parameter int ACC_W = 2*N+LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    input  logic               a_valid,
    output logic               a_ready,
    input  logic [N-1:0]       a_x,
    input  logic [N-1:0]       a_y,
    output logic [N-1:0]       mul_x,
    output logic [N-1:0]       mul_y,
    input  logic [2*N-1:0]     mul_z,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ACC_W-1:0]   res_data,
    output logic               res_ovf
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MUL,
        ACC,
        DONE
    } state_t;

    state_t state, state_d;

    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        count;
    logic [LEN_W-1:0]        count_nx;
    logic signed [2*N-1:0]   prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] sum;
    logic                    ovf;
    logic                    ovf_add;
    logic                    clr;
    logic                    take;
    logic                    last;

    assign count_nx = count + {{(LEN_W-1){1'b0}}, 1'b1};
    assign last     = (count_nx == len_q);

    // Product is sign-extended (or truncated) to the accumulator width.
    assign ext     = ACC_W'(prod);
    assign sum     = acc + ext;
    assign ovf_add = (acc[ACC_W-1] == ext[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc[ACC_W-1]);

    assign busy      = (state != IDLE);
    assign a_ready   = (state == FETCH);
    assign res_valid = (state == DONE);
    assign res_data  = acc;
    assign res_ovf   = ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        clr     = 1'b0;
        take    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    state_d = (len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (a_valid) begin
                    take    = 1'b1;
                    state_d = MUL;
                end
            end
            MUL: begin
                state_d = ACC;
            end
            ACC: begin
                state_d = last ? DONE : FETCH;
            end
            DONE: begin
                if (res_ready) begin
                    if (start) begin
                        clr     = 1'b1;
                        state_d = (len == '0) ? DONE : FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            count <= '0;
            acc   <= '0;
            ovf   <= 1'b0;
            prod  <= '0;
            mul_x <= '0;
            mul_y <= '0;
        end else begin
            if (clr) begin
                len_q <= len;
                count <= '0;
                acc   <= '0;
                ovf   <= 1'b0;
            end else if (state == ACC) begin
                count <= count_nx;
                acc   <= sum;
                ovf   <= ovf | ovf_add;
            end
            if (take) begin
                mul_x <= a_x;
                mul_y <= a_y;
            end
            if (state == MUL) begin
                prod <= mul_z;
            end
        end
    end

endmodule

// File: tb/tb_booth_dot_scheduler.sv
// Directed bench for booth_dot_scheduler with a behavioural multiplier.
module tb_booth_dot_scheduler;

    localparam int N     = 4;
    localparam int LEN_W = 4;
    localparam int ACC_W = 2*N+LEN_W;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             a_valid;
    logic [N-1:0]     a_x;
    logic [N-1:0]     a_y;
    logic             res_ready;

    logic             busy, a_ready, res_valid, res_ovf;
    logic [N-1:0]     mul_x, mul_y;
    logic [2*N-1:0]   mul_z;
    logic [ACC_W-1:0] res_data;

    logic             busy8, a_ready8, res_valid8, res_ovf8;
    logic [N-1:0]     mul_x8, mul_y8;
    logic [2*N-1:0]   mul_z8;
    logic [7:0]       res_data8;

    int ncmp = 0;
    int nerr = 0;
    int px[4];
    int py[4];
    int stall_idx;
    int stall_n;
    int lat;
    int ar_cnt;
    int busy_low;
    logic [ACC_W-1:0] hold;

    assign mul_z  = $signed(mul_x) * $signed(mul_y);
    assign mul_z8 = $signed(mul_x8) * $signed(mul_y8);

    booth_dot_scheduler #(.N(N), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .busy(busy), .a_valid(a_valid), .a_ready(a_ready),
        .a_x(a_x), .a_y(a_y), .mul_x(mul_x), .mul_y(mul_y),
        .mul_z(mul_z), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_ovf(res_ovf)
    );

    booth_dot_scheduler #(.N(N), .LEN_W(LEN_W), .ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .busy(busy8), .a_valid(a_valid), .a_ready(a_ready8),
        .a_x(a_x), .a_y(a_y), .mul_x(mul_x8), .mul_y(mul_y8),
        .mul_z(mul_z8), .res_valid(res_valid8), .res_ready(res_ready),
        .res_data(res_data8), .res_ovf(res_ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; starts a job (optionally as a DONE handshake)
    // and feeds pairs until res_valid, recording latency in cycles.
    task automatic run(input int n, input bit b2b);
        int idx;
        int stalled;
        start     = 1'b1;
        len       = LEN_W'(n);
        res_ready = b2b;
        idx       = 0;
        stalled   = 0;
        lat       = 0;
        ar_cnt    = 0;
        busy_low  = 0;
        a_valid   = 1'b0;
        forever begin
            @(negedge clk);
            start     = 1'b0;
            res_ready = 1'b0;
            lat++;
            if (!busy) busy_low++;
            if (a_ready) ar_cnt++;
            if (res_valid) break;
            if (lat > 200) begin
                chk("timeout", lat, 0);
                break;
            end
            a_valid = 1'b0;
            if (a_ready && idx < n) begin
                if (idx == stall_idx && stalled < stall_n) begin
                    stalled++;
                end else begin
                    a_valid = 1'b1;
                    a_x     = N'(px[idx]);
                    a_y     = N'(py[idx]);
                    idx++;
                end
            end
        end
        a_valid = 1'b0;
    endtask

    // Start is offered without res_ready and must be ignored; then consume.
    task automatic consume(input string tag);
        hold      = res_data;
        start     = 1'b1;
        len       = 4'd5;
        res_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_hold_valid"}, res_valid, 1);
        chk({tag, "_hold_data"}, $signed(res_data), $signed(hold));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        a_valid   = 1'b0;
        a_x       = '0;
        a_y       = '0;
        res_ready = 1'b0;
        stall_idx = -1;
        stall_n   = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_ovf", res_ovf, 0);
        chk("rst_res_data", $signed(res_data), 0);
        chk("rst_mul_x", $signed(mul_x), 0);
        rst_n = 1'b1;
        @(negedge clk);

        px = '{2, -1, 7, 0};
        py = '{3, 5, -2, 0};
        run(3, 1'b0);
        chk("t1_lat", lat, 10);
        chk("t1_data", $signed(res_data), -13);
        chk("t1_ovf", res_ovf, 0);
        chk("t1_mulx_hold", $signed(mul_x), 7);
        chk("t1_muly_hold", $signed(mul_y), -2);
        consume("t1");

        px = '{7, 7, 7, 0};
        py = '{7, 7, 7, 0};
        run(3, 1'b0);
        chk("t2_lat", lat, 10);
        chk("t2_data8", $signed(res_data8), -109);
        chk("t2_ovf8", res_ovf8, 1);
        chk("t2_data12", $signed(res_data), 147);
        chk("t2_ovf12", res_ovf, 0);
        consume("t2");
        chk("t2_ovf8_sticky", res_ovf8, 1);

        run(0, 1'b0);
        chk("t3_lat", lat, 1);
        chk("t3_data", $signed(res_data), 0);
        chk("t3_no_a_ready", ar_cnt, 0);
        chk("t3_ovf8_clr", res_ovf8, 0);
        consume("t3");

        px = '{2, -1, 7, 0};
        py = '{3, 5, -2, 0};
        stall_idx = 1;
        stall_n   = 5;
        run(3, 1'b0);
        stall_idx = -1;
        stall_n   = 0;
        chk("t4_lat", lat, 15);
        chk("t4_data", $signed(res_data), -13);
        consume("t4");

        start   = 1'b1;
        len     = 4'd3;
        a_valid = 1'b1;
        a_x     = 4'd2;
        a_y     = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a_x = 4'hf;
        a_y = 4'd5;
        @(negedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        chk("t5_mid_mulx", $signed(mul_x), -1);
        chk("t5_mid_acc", $signed(res_data), 6);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_data", $signed(res_data), 0);
        chk("t5_rst_mulx", $signed(mul_x), 0);
        chk("t5_rst_muly", $signed(mul_y), 0);
        @(negedge clk);
        rst_n = 1'b1;
        px = '{3, 0, 0, 0};
        py = '{-3, 0, 0, 0};
        run(1, 1'b0);
        chk("t5_lat", lat, 4);
        chk("t5_data", $signed(res_data), -9);
        consume("t5");

        px = '{1, 1, 0, 0};
        py = '{1, 1, 0, 0};
        run(2, 1'b0);
        chk("t6_lat1", lat, 7);
        chk("t6_data1", $signed(res_data), 2);
        run(2, 1'b1);
        chk("t6_lat2", lat, 7);
        chk("t6_busy_low", busy_low, 0);
        chk("t6_data2", $signed(res_data), 2);
        consume("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
